fsb_ws_timer: RTL and testbench

- FSB-side consumer of the wait-state configuration outputs (ROMWS, RAMWS, IOWS) driven by the configuration block.
- Decodes each accelerated 68000 bus cycle into a RAM, ROM or IO region and inserts the configured number of wait states.
- Then asserts nDTACK_FSB to the CPU and holds it until the CPU releases nAS_FSB.
- IO cycles additionally wait for the downstream IO bridge to report completion.

---
 rtl/fsb_pkg.sv | 20 ++
 rtl/fsb_region_decode.sv | 11 +
 rtl/fsb_ws_timer.sv | 127 ++++++++++++
 tb/tb_fsb_ws_timer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsb_pkg.sv
// rtl/fsb_pkg.sv - shared FSB types, region decode constants and decode function
package fsb_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, IOWAIT, ACK, BERR} state_e;
  typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_IO} region_e;

  localparam logic [1:0] RAM_PREFIX = 2'b00;
  localparam logic [3:0] ROM_NIBBLE = 4'h4;

  function automatic region_e fsb_region(input logic [3:0] a);
    if (a[3:2] == RAM_PREFIX) begin
      return REG_RAM;
    end else if (a == ROM_NIBBLE) begin
      return REG_ROM;
    end else begin
      return REG_IO;
    end
  endfunction

endpackage

// File: rtl/fsb_region_decode.sv
// rtl/fsb_region_decode.sv - combinational A_FSB[23:20] to RAM/ROM/IO region decode
module fsb_region_decode
  import fsb_pkg::*;
(
  input  logic [3:0] i_addr,
  output region_e    o_region
);

  assign o_region = fsb_region(i_addr);

endmodule

// File: rtl/fsb_ws_timer.sv
// rtl/fsb_ws_timer.sv - FSB wait-state timer and DTACK generator
// Optional IO timeout / bus error path enabled by FSB_IO_TIMEOUT_EN.
module fsb_ws_timer
  import fsb_pkg::*;
#(
  parameter int RAM_WS = 2,
  parameter int ROM_WS = 3,
  parameter int IO_WS  = 4,
  parameter int CNT_W  = 3
`ifdef FSB_IO_TIMEOUT_EN
  ,
  parameter int TO_CYC = 255
`endif
)
(
  input  logic       FCLK,
  input  logic       RES,
  input  logic [3:0] A_FSB,
  input  logic       nAS_FSB,
  input  logic       ROMWS,
  input  logic       RAMWS,
  input  logic       IOWS,
  input  logic       IOReady,
  output logic       nDTACK_FSB,
  output logic       IOStart,
  output logic       Busy,
  output logic       nBERR_FSB
);

  state_e           r_state;
  state_e           w_next;
  region_e          r_region;
  region_e          w_region;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load_cnt;
  logic             r_armed;
  logic             r_iostart;
  logic             w_start;

  fsb_region_decode u_decode (
    .i_addr   (A_FSB),
    .o_region (w_region)
  );

  always_comb begin
    w_load_cnt = '0;
    case (w_region)
      REG_RAM: if (RAMWS) w_load_cnt = CNT_W'(RAM_WS);
      REG_ROM: if (ROMWS) w_load_cnt = CNT_W'(ROM_WS);
      default: if (IOWS)  w_load_cnt = CNT_W'(IO_WS);
    endcase
  end

  // A cycle starts only if nAS was sampled high in IDLE on the previous edge.
  assign w_start = (r_state == IDLE) && r_armed && !nAS_FSB;

`ifdef FSB_IO_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       w_timeout;

  assign w_timeout = (r_to_cnt == 8'(TO_CYC - 1));

  always_ff @(posedge FCLK or posedge RES) begin
    if (RES) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= (r_state == IOWAIT) ? r_to_cnt + 8'd1 : 8'd0;
    end
  end

  assign nBERR_FSB = (r_state != BERR);
`else
  assign nBERR_FSB = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_load_cnt != '0)      w_next = WAIT;
          else if (w_region == REG_IO) w_next = IOWAIT;
          else                       w_next = ACK;
        end
      end
      WAIT: begin
        if (nAS_FSB)                      w_next = IDLE;
        else if (r_cnt == CNT_W'(1))      w_next = (r_region == REG_IO) ? IOWAIT : ACK;
      end
      IOWAIT: begin
        if (nAS_FSB)      w_next = IDLE;
        else if (IOReady) w_next = ACK;
`ifdef FSB_IO_TIMEOUT_EN
        else if (w_timeout) w_next = BERR;
`endif
      end
      ACK:     if (nAS_FSB) w_next = IDLE;
      BERR:    if (nAS_FSB) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge FCLK or posedge RES) begin
    if (RES) begin
      r_state   <= IDLE;
      r_region  <= REG_RAM;
      r_cnt     <= '0;
      r_armed   <= 1'b0;
      r_iostart <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_armed   <= (r_state == IDLE) && nAS_FSB;
      r_iostart <= (w_next == IOWAIT) && (r_state != IOWAIT);
      if (w_start) begin
        r_region <= w_region;
        r_cnt    <= w_load_cnt;
      end else if ((r_state == WAIT) && (r_cnt > CNT_W'(1))) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign nDTACK_FSB = (r_state != ACK);
  assign Busy       = (r_state != IDLE);
  assign IOStart    = r_iostart;

endmodule

// File: tb/tb_fsb_ws_timer.sv
// tb/tb_fsb_ws_timer.sv - randomized self-checking bench for fsb_ws_timer
module tb_fsb_ws_timer;

  localparam int RAM_WS = 2;
  localparam int ROM_WS = 3;
  localparam int IO_WS  = 4;

  logic       FCLK = 1'b0;
  logic       RES;
  logic [3:0] A_FSB;
  logic       nAS_FSB;
  logic       ROMWS;
  logic       RAMWS;
  logic       IOWS;
  logic       IOReady;
  logic       nDTACK_FSB;
  logic       IOStart;
  logic       Busy;
  logic       nBERR_FSB;

  int checks = 0;
  int errors = 0;

  always #5 FCLK = ~FCLK;

  fsb_ws_timer #(
    .RAM_WS (RAM_WS),
    .ROM_WS (ROM_WS),
    .IO_WS  (IO_WS),
    .CNT_W  (3)
  ) dut (
    .FCLK       (FCLK),
    .RES        (RES),
    .A_FSB      (A_FSB),
    .nAS_FSB    (nAS_FSB),
    .ROMWS      (ROMWS),
    .RAMWS      (RAMWS),
    .IOWS       (IOWS),
    .IOReady    (IOReady),
    .nDTACK_FSB (nDTACK_FSB),
    .IOStart    (IOStart),
    .Busy       (Busy),
    .nBERR_FSB  (nBERR_FSB)
  );

  function automatic bit model_is_io(input logic [3:0] a);
    return (a[3:2] != 2'b00) && (a != 4'b0100);
  endfunction

  function automatic int model_ws(input logic [3:0] a, input logic romws, input logic ramws,
                                  input logic iows);
    if (a[3:2] == 2'b00) return ramws ? RAM_WS : 0;
    if (a == 4'b0100)    return romws ? ROM_WS : 0;
    return iows ? IO_WS : 0;
  endfunction

  // Edge 0 is the first edge sampling nAS low; nAS stays low through edge hold.
  // IOReady is high at every edge after edge rdy (rdy = -1 means already high).
  task automatic do_txn(input logic [3:0] a, input logic romws, input logic ramws,
                        input logic iows, input int rdy, input int hold, input string tag);
    int   n;
    int   ack;
    bit   io;
    logic e_dtack, e_busy, e_start;
    io  = model_is_io(a);
    n   = model_ws(a, romws, ramws, iows);
    ack = io ? (((n > rdy) ? n : rdy) + 1) : n;
    for (int j = 0; j <= hold + 2; j++) begin
      nAS_FSB = (j <= hold) ? 1'b0 : 1'b1;
      IOReady = (j > rdy);
      if (j == 0) begin
        A_FSB = a; ROMWS = romws; RAMWS = ramws; IOWS = iows;
      end else begin
        A_FSB = 4'($urandom); ROMWS = 1'($urandom); RAMWS = 1'($urandom); IOWS = 1'($urandom);
      end
      @(posedge FCLK);
      @(negedge FCLK);
      e_busy  = (j <= hold);
      e_dtack = !((j >= ack) && (j <= hold));
      e_start = io && (j == n) && (n <= hold);
      checks += 4;
      if (nDTACK_FSB !== e_dtack) begin
        errors++;
        $display("FAIL %s nDTACK edge %0d got %b exp %b", tag, j, nDTACK_FSB, e_dtack);
      end
      if (Busy !== e_busy) begin
        errors++;
        $display("FAIL %s Busy edge %0d got %b exp %b", tag, j, Busy, e_busy);
      end
      if (IOStart !== e_start) begin
        errors++;
        $display("FAIL %s IOStart edge %0d got %b exp %b", tag, j, IOStart, e_start);
      end
      if (nBERR_FSB !== 1'b1) begin
        errors++;
        $display("FAIL %s nBERR edge %0d got %b exp 1", tag, j, nBERR_FSB);
      end
    end
    IOReady = 1'b0;
  endtask

  task automatic test_reset;
    RES = 1'b1; nAS_FSB = 1'b1; A_FSB = 4'h0; ROMWS = 1'b0; RAMWS = 1'b0; IOWS = 1'b0;
    IOReady = 1'b0;
    repeat (3) @(negedge FCLK);
    checks++;
    if ({nDTACK_FSB, IOStart, Busy, nBERR_FSB} !== 4'b1001) begin
      errors++;
      $display("FAIL reset outputs got %b exp 1001", {nDTACK_FSB, IOStart, Busy, nBERR_FSB});
    end
    RES = 1'b0;
    repeat (2) @(negedge FCLK);
  endtask

  task automatic test_directed;
    do_txn(4'h0, 1'b0, 1'b0, 1'b0, 100, 10, "ram0");
    do_txn(4'h4, 1'b1, 1'b0, 1'b0, 100, 6, "rom3");
    do_txn(4'h5, 1'b0, 1'b0, 1'b1, 9, 12, "io4");
    do_txn(4'h9, 1'b0, 1'b0, 1'b0, -1, 3, "io_ready_early");
    do_txn(4'h4, 1'b1, 1'b0, 1'b0, 100, 1, "rom_abort");
    do_txn(4'h2, 1'b0, 1'b1, 1'b0, 100, 4, "ram_after_abort");
    do_txn(4'hC, 1'b0, 1'b0, 1'b1, 100, 7, "io_abort");
  endtask

  task automatic test_random;
    for (int t = 0; t < 40; t++) begin
      do_txn(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 9) - 1, $urandom_range(0, 14), "random");
    end
  endtask

  task automatic test_back_to_back;
    nAS_FSB = 1'b0; A_FSB = 4'h1; RAMWS = 1'b0;
    @(posedge FCLK); @(negedge FCLK);
    checks++;
    if (nDTACK_FSB !== 1'b0) begin
      errors++; $display("FAIL b2b first ack got %b exp 0", nDTACK_FSB);
    end
    nAS_FSB = 1'b1;
    @(posedge FCLK); @(negedge FCLK);
    nAS_FSB = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge FCLK); @(negedge FCLK);
      checks++;
      if (Busy !== 1'b0) begin
        errors++; $display("FAIL b2b early accept cycle %0d Busy got %b exp 0", j, Busy);
      end
    end
    nAS_FSB = 1'b1;
    @(posedge FCLK); @(negedge FCLK);
    nAS_FSB = 1'b0;
    @(posedge FCLK); @(negedge FCLK);
    checks++;
    if (nDTACK_FSB !== 1'b0) begin
      errors++; $display("FAIL b2b second ack got %b exp 0", nDTACK_FSB);
    end
    nAS_FSB = 1'b1;
    repeat (2) @(negedge FCLK);
  endtask

  task automatic test_reset_in_ack;
    nAS_FSB = 1'b0; A_FSB = 4'h3; RAMWS = 1'b0;
    @(posedge FCLK); @(negedge FCLK);
    checks++;
    if (nDTACK_FSB !== 1'b0) begin
      errors++; $display("FAIL rst_ack pre ack got %b exp 0", nDTACK_FSB);
    end
    @(posedge FCLK); #2 RES = 1'b1; #1;
    checks++;
    if ({nDTACK_FSB, Busy, IOStart} !== 3'b100) begin
      errors++; $display("FAIL rst_ack async got %b exp 100", {nDTACK_FSB, Busy, IOStart});
    end
    @(negedge FCLK); RES = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge FCLK); @(negedge FCLK);
      checks++;
      if (Busy !== 1'b0) begin
        errors++; $display("FAIL rst_ack held nAS cycle %0d Busy got %b exp 0", j, Busy);
      end
    end
    nAS_FSB = 1'b1;
    @(posedge FCLK); @(negedge FCLK);
    nAS_FSB = 1'b0;
    @(posedge FCLK); @(negedge FCLK);
    checks++;
    if (nDTACK_FSB !== 1'b0) begin
      errors++; $display("FAIL rst_ack fresh cycle ack got %b exp 0", nDTACK_FSB);
    end
    nAS_FSB = 1'b1;
    repeat (2) @(negedge FCLK);
  endtask

`ifdef FSB_IO_TIMEOUT_EN
  task automatic test_timeout;
    nAS_FSB = 1'b0; A_FSB = 4'hF; IOWS = 1'b0; IOReady = 1'b0;
    for (int j = 0; j <= 258; j++) begin
      @(posedge FCLK); @(negedge FCLK);
      checks += 2;
      if (nBERR_FSB !== ((j >= 255) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL timeout nBERR edge %0d got %b", j, nBERR_FSB);
      end
      if (nDTACK_FSB !== 1'b1) begin
        errors++; $display("FAIL timeout nDTACK edge %0d got %b exp 1", j, nDTACK_FSB);
      end
    end
    nAS_FSB = 1'b1;
    @(posedge FCLK); @(negedge FCLK);
    checks++;
    if ({nBERR_FSB, Busy} !== 2'b10) begin
      errors++; $display("FAIL timeout release got %b exp 10", {nBERR_FSB, Busy});
    end
    repeat (2) @(negedge FCLK);
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_in_ack;
    test_random;
`ifdef FSB_IO_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
